// File: rtl/display_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scan driver with per-slot blanking and
// a once-per-frame input snapshot so a frame never mixes old and new digits.
module display_scan_driver #(
    parameter int unsigned DIGIT_PERIOD   = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] disp,
    input  logic [7:0]  disp_en,
    input  logic [7:0]  disp_dot,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    // XOR masks that map active-high drive values onto the pin polarity.
    localparam logic [7:0] AN_OFF  = AN_ACTIVE_LOW  ? 8'hFF : 8'h00;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      snap_disp;
    logic [7:0]       snap_en;
    logic [7:0]       snap_dot;

    logic             frame_last_c;
    logic             lit_c;
    logic [3:0]       digit_c;
    logic [7:0]       an_c;
    logic [6:0]       seg_c;
    logic             dp_c;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        return pattern;
    endfunction

    assign frame_last_c = (cnt == CNT_LAST) && (idx == 3'd7);

    // Drive decision for the current slot position, active-high form.
    always_comb begin
        digit_c = snap_disp[{idx, 2'b00} +: 4];
        lit_c   = (cnt >= BLANK_END) && snap_en[idx];
        an_c    = 8'h00;
        seg_c   = 7'h00;
        dp_c    = 1'b0;
        if (lit_c) begin
            an_c  = 8'b1 << idx;
            seg_c = hex_decode(digit_c);
            dp_c  = snap_dot[idx];
        end
    end

    // Slot counter and digit index; idx wraps naturally at 7.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Inputs are captured only at the frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_disp  <= '0;
            snap_en    <= '0;
            snap_dot   <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_last_c;
            if (frame_last_c) begin
                snap_disp <= disp;
                snap_en   <= disp_en;
                snap_dot  <= disp_dot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= an_c ^ AN_OFF;
            seg <= seg_c ^ SEG_OFF;
            dp  <= dp_c ^ DP_OFF;
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench: a cycle-position reference model predicts the pins after
// every clock edge; a monitor on the falling edge compares them.
module tb_display_scan_driver;

    localparam int unsigned DP    = 8;
    localparam int unsigned BLANK = 2;
    localparam int unsigned FRAME = 8 * DP;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] disp;
    logic [7:0]  disp_en;
    logic [7:0]  disp_dot;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int total;
    int bad;
    exp_t q[$];
    logic [6:0] hex_tab [16];

    display_scan_driver #(
        .DIGIT_PERIOD  (DP),
        .BLANK_CYCLES  (BLANK),
        .AN_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .disp      (disp),
        .disp_en   (disp_en),
        .disp_dot  (disp_dot),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    // Reference model: p counts cycles since reset release; slot, position
    // and frame membership all follow from p by plain division.
    initial begin
        int unsigned p;
        int unsigned slot;
        int unsigned pos;
        bit          lit;
        logic [31:0] m_disp;
        logic [7:0]  m_en;
        logic [7:0]  m_dot;
        logic [3:0]  digit;
        exp_t        e;
        p = 0;
        m_disp = '0;
        m_en = '0;
        m_dot = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                p = 0;
                m_disp = '0;
                m_en = '0;
                m_dot = '0;
                e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
            end else begin
                slot  = (p / DP) % 8;
                pos   = p % DP;
                lit   = (pos >= BLANK) && m_en[slot];
                digit = 4'((m_disp >> (4 * slot)) & 32'hF);
                e.an  = lit ? ~(8'h01 << slot) : 8'hFF;
                e.seg = lit ? ~hex_tab[digit] : 7'h7F;
                e.dp  = ~(lit && m_dot[slot]);
                e.ft  = ((p % FRAME) == FRAME - 1);
                if (e.ft) begin
                    m_disp = disp;
                    m_en   = disp_en;
                    m_dot  = disp_dot;
                end
                p++;
            end
            q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, want);
        end
    endtask

    // Monitor: every cycle presents a pin state; compare it to the prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("an", an, e.an);
                check("seg", {1'b0, seg}, {1'b0, e.seg});
                check("dp", {7'b0, dp}, {7'b0, e.dp});
                check("frame_tick", {7'b0, frame_tick}, {7'b0, e.ft});
                check("one_hot_an", 8'($countones(~an) > 1), 8'h00);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for frame_tick; an expired budget is a failed comparison.
    task automatic wait_tick(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_tick at %0t: no frame_tick within %0d cycles", $time, budget);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        disp = '0;
        disp_en = '0;
        disp_dot = '0;
        cycles(3);
        rst_n = 1'b1;

        // First frame stays dark; inputs load at its boundary.
        disp = 32'h7654_3210;
        disp_en = 8'hFF;
        disp_dot = 8'h00;
        wait_tick(FRAME + 4);

        // Mid-frame change must not tear the current frame.
        cycles(20);
        disp = 32'hFFFF_FFFF;
        wait_tick(FRAME + 4);
        cycles(10);

        disp_en = 8'h0F;
        wait_tick(FRAME + 4);
        wait_tick(FRAME + 4);

        disp_dot = 8'h80;
        disp_en = 8'hFF;
        wait_tick(FRAME + 4);
        wait_tick(FRAME + 4);
        disp_en = 8'h7F;
        wait_tick(FRAME + 4);
        wait_tick(FRAME + 4);

        // One-cycle reset during slot 5 clears the snapshot.
        cycles(5 * DP + 3);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        wait_tick(FRAME + 4);
        wait_tick(FRAME + 4);

        // Randomized inputs, phases and occasional resets.
        for (int i = 0; i < 40; i++) begin
            disp = $urandom;
            disp_en = 8'($urandom);
            disp_dot = 8'($urandom);
            cycles($urandom_range(1, 100));
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                cycles($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        wait_tick(FRAME + 4);
        cycles(FRAME + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
